// File: rtl/tqvp_bus_pkg.sv
// tqvp_bus_pkg: size/strobe encodings, FSM states and command record shared by the peripheral initiator
//   exports SIZE_* encodings, BUS_IDLE strobe value, state_t, cmd_t and size_mask()
package tqvp_bus_pkg;
   localparam logic [1:0] SIZE_8       = 2'b00;
   localparam logic [1:0] SIZE_16      = 2'b01;
   localparam logic [1:0] SIZE_32      = 2'b10;
   localparam logic [1:0] SIZE_ILLEGAL = 2'b11;
   localparam logic [1:0] BUS_IDLE     = 2'b11;
   typedef enum logic [1:0] {IDLE, ISSUE, READ, RESP} state_t;
   typedef struct packed {
      logic        write;
      logic [1:0]  size;
      logic [5:0]  addr;
      logic [31:0] wdata;
   } cmd_t;
   function automatic logic [31:0] size_mask(input logic [1:0] s, input logic [31:0] d);
      return s == SIZE_8 ? {24'h0, d[7:0]} : s == SIZE_16 ? {16'h0, d[15:0]} : s == SIZE_32 ? d : 32'h0;
   endfunction
endpackage

// File: rtl/tqvp_cmd_fifo.sv
// tqvp_cmd_fifo: synchronous command FIFO, DEPTH entries (power of 2) of W bits
//   push/pop must be pre-qualified by the caller with !full / !empty
//   dout shows the head entry; full, empty and count reflect occupancy
module tqvp_cmd_fifo #(
   parameter int DEPTH = 4,
   parameter int W = 41
) (
   input  logic                     clk,
   input  logic                     rst_n,
   input  logic                     push,
   input  logic                     pop,
   input  logic [W-1:0]             din,
   output logic [W-1:0]             dout,
   output logic                     full,
   output logic                     empty,
   output logic [$clog2(DEPTH):0]   count
);
   localparam int AW = $clog2(DEPTH);
   localparam int CW = AW + 1;
   logic [W-1:0]  mem [DEPTH];
   logic [AW-1:0] wp, rp;
   assign dout  = mem[rp];
   assign full  = count == CW'(DEPTH);
   assign empty = count == '0;
   always_ff @(posedge clk)
      if (push) mem[wp] <= din;
   always_ff @(posedge clk or negedge rst_n)
      if (!rst_n) begin
         wp    <= '0;
         rp    <= '0;
         count <= '0;
      end else begin
         if (push) wp <= wp + AW'(1);
         if (pop) rp <= rp + AW'(1);
         count <= count + CW'(push) - CW'(pop);
      end
endmodule

// File: rtl/tqvp_periph_initiator.sv
// tqvp_periph_initiator: queued read/write initiator driving a TinyQV tqvp_* peripheral port
//   cmd_*  : command stream in (valid/ready), buffered in a FIFO_DEPTH-entry FIFO
//   rsp_*  : one response per command (write ack, masked read data, or error), held until rsp_ready
//   p_*    : peripheral address/data/strobes; strobes are 2'b11 when idle
//   busy   : FSM active or commands still queued
module tqvp_periph_initiator
   import tqvp_bus_pkg::*;
#(
   parameter int FIFO_DEPTH     = 4,
   parameter int TIMEOUT_CYCLES = 15
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        cmd_valid,
   output logic        cmd_ready,
   input  logic        cmd_write,
   input  logic [1:0]  cmd_size,
   input  logic [5:0]  cmd_addr,
   input  logic [31:0] cmd_wdata,
   output logic        rsp_valid,
   input  logic        rsp_ready,
   output logic        rsp_write,
   output logic        rsp_error,
   output logic [31:0] rsp_rdata,
   output logic        busy,
   output logic [5:0]  p_address,
   output logic [31:0] p_wdata,
   output logic [1:0]  p_write_n,
   output logic [1:0]  p_read_n,
   input  logic [31:0] p_rdata,
   input  logic        p_ready
);
   state_t                      state;
   cmd_t                        cmd_in, head;
   logic                        full, empty, push, pop;
   logic [$clog2(FIFO_DEPTH):0] count;
   logic                        cur_write;
   logic [1:0]                  cur_size;
   logic [7:0]                  wait_cnt;
   assign cmd_in    = '{write: cmd_write, size: cmd_size, addr: cmd_addr, wdata: cmd_wdata};
   assign cmd_ready = !full;
   assign push      = cmd_valid && !full;
   assign pop       = state == IDLE && !empty;
   assign busy      = state != IDLE || count != '0;
   tqvp_cmd_fifo #(.DEPTH(FIFO_DEPTH), .W($bits(cmd_t))) u_fifo (
      .clk   (clk),
      .rst_n (rst_n),
      .push  (push),
      .pop   (pop),
      .din   (cmd_in),
      .dout  (head),
      .full  (full),
      .empty (empty),
      .count (count)
   );
   // Strobes are set on the IDLE->ISSUE edge so they are visible during ISSUE;
   // wait_cnt counts strobe cycles already shown, starting at 1 for the first.
   always_ff @(posedge clk or negedge rst_n)
      if (!rst_n) begin
         state     <= IDLE;
         cur_write <= 1'b0;
         cur_size  <= SIZE_8;
         wait_cnt  <= '0;
         p_address <= '0;
         p_wdata   <= '0;
         p_write_n <= BUS_IDLE;
         p_read_n  <= BUS_IDLE;
         rsp_valid <= 1'b0;
         rsp_write <= 1'b0;
         rsp_error <= 1'b0;
         rsp_rdata <= '0;
      end else begin
         case (state)
            IDLE: if (pop) begin
               cur_write <= head.write;
               cur_size  <= head.size;
               p_address <= head.addr;
               p_wdata   <= head.wdata;
               wait_cnt  <= 8'd1;
               if (head.size != SIZE_ILLEGAL) begin
                  if (head.write) p_write_n <= head.size;
                  else p_read_n <= head.size;
               end
               state <= ISSUE;
            end
            ISSUE, READ: begin
               if (cur_size == SIZE_ILLEGAL || cur_write || p_ready || wait_cnt == 8'(TIMEOUT_CYCLES)) begin
                  p_write_n <= BUS_IDLE;
                  p_read_n  <= BUS_IDLE;
                  rsp_valid <= 1'b1;
                  rsp_write <= cur_write;
                  rsp_error <= cur_size == SIZE_ILLEGAL || (!cur_write && !p_ready);
                  rsp_rdata <= cur_size != SIZE_ILLEGAL && !cur_write && p_ready ? size_mask(cur_size, p_rdata) : 32'h0;
                  state     <= RESP;
               end else begin
                  wait_cnt <= wait_cnt + 8'd1;
                  state    <= READ;
               end
            end
            RESP: if (rsp_ready) begin
               rsp_valid <= 1'b0;
               state     <= IDLE;
            end
            default: state <= IDLE;
         endcase
      end
endmodule

// File: tb/tb_tqvp_periph_initiator.sv
// tb_tqvp_periph_initiator: directed vector table plus multi-cycle sequences for the peripheral initiator
module tb_tqvp_periph_initiator;
   logic        clk, rst_n;
   logic        cmd_valid, cmd_ready, cmd_write;
   logic [1:0]  cmd_size;
   logic [5:0]  cmd_addr;
   logic [31:0] cmd_wdata;
   logic        rsp_valid, rsp_ready, rsp_write, rsp_error;
   logic [31:0] rsp_rdata;
   logic        busy;
   logic [5:0]  p_address;
   logic [31:0] p_wdata;
   logic [1:0]  p_write_n, p_read_n;
   logic [31:0] p_rdata;
   logic        p_ready;
   int checks = 0;
   int errors = 0;
   tqvp_periph_initiator #(.FIFO_DEPTH(4), .TIMEOUT_CYCLES(15)) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .cmd_valid (cmd_valid),
      .cmd_ready (cmd_ready),
      .cmd_write (cmd_write),
      .cmd_size  (cmd_size),
      .cmd_addr  (cmd_addr),
      .cmd_wdata (cmd_wdata),
      .rsp_valid (rsp_valid),
      .rsp_ready (rsp_ready),
      .rsp_write (rsp_write),
      .rsp_error (rsp_error),
      .rsp_rdata (rsp_rdata),
      .busy      (busy),
      .p_address (p_address),
      .p_wdata   (p_wdata),
      .p_write_n (p_write_n),
      .p_read_n  (p_read_n),
      .p_rdata   (p_rdata),
      .p_ready   (p_ready)
   );
   initial clk = 1'b0;
   always #5 clk = ~clk;
   typedef struct {
      logic        wr;
      logic [1:0]  sz;
      logic [5:0]  addr;
      logic [31:0] wdata;
      logic [31:0] prd;
      logic [1:0]  ewn;
      logic [1:0]  ern;
      logic        eerr;
      logic [31:0] erd;
   } vec_t;
   vec_t vecs [8];
   logic       mon_en = 1'b0;
   logic       prev_act = 1'b0;
   int         b2b_viol = 0;
   int         rsp_cnt = 0;
   logic [5:0] addr_q [$];
   always @(negedge clk) begin
      if (mon_en) begin
         if (p_write_n != 2'b11) addr_q.push_back(p_address);
         if (p_write_n != 2'b11 && prev_act) b2b_viol++;
         if (rsp_valid && rsp_ready) rsp_cnt++;
      end
      prev_act = p_write_n != 2'b11 || p_read_n != 2'b11;
   end
   task automatic tick;
      @(posedge clk);
      #1;
   endtask
   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s got %h want %h", nm, act, exp);
      end
   endtask
   task automatic send(input logic wr, input logic [1:0] sz, input logic [5:0] a, input logic [31:0] d);
      cmd_write = wr;
      cmd_size  = sz;
      cmd_addr  = a;
      cmd_wdata = d;
      cmd_valid = 1'b1;
      tick;
      cmd_valid = 1'b0;
   endtask
   task automatic drain;
      int n = 0;
      rsp_ready = 1'b1;
      while ((busy || rsp_valid) && n < 60) begin
         tick;
         n++;
      end
      rsp_ready = 1'b0;
      chk("drain_idle", {31'h0, busy || rsp_valid}, 32'h0);
   endtask
   initial begin
      vecs[0] = '{1'b1, 2'b10, 6'h00, 32'h6000_0005, 32'h0,          2'b10, 2'b11, 1'b0, 32'h0};
      vecs[1] = '{1'b0, 2'b00, 6'h18, 32'h0,          32'hDEAD_BEA5, 2'b11, 2'b00, 1'b0, 32'h0000_00A5};
      vecs[2] = '{1'b0, 2'b01, 6'h05, 32'h0,          32'h1234_5678, 2'b11, 2'b01, 1'b0, 32'h0000_5678};
      vecs[3] = '{1'b0, 2'b10, 6'h3F, 32'h0,          32'hCAFE_F00D, 2'b11, 2'b10, 1'b0, 32'hCAFE_F00D};
      vecs[4] = '{1'b1, 2'b00, 6'h2A, 32'hFFFF_FFFF, 32'h5555_5555, 2'b00, 2'b11, 1'b0, 32'h0};
      vecs[5] = '{1'b1, 2'b01, 6'h01, 32'h0BAD_F00D, 32'h0,          2'b01, 2'b11, 1'b0, 32'h0};
      vecs[6] = '{1'b0, 2'b11, 6'h11, 32'h0,          32'h8765_4321, 2'b11, 2'b11, 1'b1, 32'h0};
      vecs[7] = '{1'b1, 2'b11, 6'h22, 32'h1111_2222, 32'h0,          2'b11, 2'b11, 1'b1, 32'h0};
      rst_n = 1'b0;
      cmd_valid = 1'b0; cmd_write = 1'b0; cmd_size = 2'b00; cmd_addr = 6'h0; cmd_wdata = 32'h0;
      rsp_ready = 1'b0; p_rdata = 32'h0; p_ready = 1'b0;
      tick;
      tick;
      chk("rst_write_n", {30'h0, p_write_n}, 32'h3);
      chk("rst_read_n", {30'h0, p_read_n}, 32'h3);
      chk("rst_address", {26'h0, p_address}, 32'h0);
      chk("rst_wdata", p_wdata, 32'h0);
      chk("rst_rsp", {29'h0, rsp_valid, rsp_write, rsp_error}, 32'h0);
      chk("rst_rdata", rsp_rdata, 32'h0);
      chk("rst_busy_ready", {30'h0, busy, cmd_ready}, 32'h1);
      rst_n = 1'b1;
      tick;
      p_ready = 1'b1;
      for (int i = 0; i < 8; i++) begin
         p_rdata = vecs[i].prd;
         send(vecs[i].wr, vecs[i].sz, vecs[i].addr, vecs[i].wdata);
         chk($sformatf("v%0d_busy", i), {31'h0, busy}, 32'h1);
         chk($sformatf("v%0d_pre_strobe", i), {28'h0, p_write_n, p_read_n}, 32'hF);
         tick;
         chk($sformatf("v%0d_write_n", i), {30'h0, p_write_n}, {30'h0, vecs[i].ewn});
         chk($sformatf("v%0d_read_n", i), {30'h0, p_read_n}, {30'h0, vecs[i].ern});
         chk($sformatf("v%0d_address", i), {26'h0, p_address}, {26'h0, vecs[i].addr});
         chk($sformatf("v%0d_wdata", i), p_wdata, vecs[i].wdata);
         chk($sformatf("v%0d_no_rsp_yet", i), {31'h0, rsp_valid}, 32'h0);
         tick;
         chk($sformatf("v%0d_rsp_valid", i), {31'h0, rsp_valid}, 32'h1);
         chk($sformatf("v%0d_rsp_write", i), {31'h0, rsp_write}, {31'h0, vecs[i].wr});
         chk($sformatf("v%0d_rsp_error", i), {31'h0, rsp_error}, {31'h0, vecs[i].eerr});
         chk($sformatf("v%0d_rsp_rdata", i), rsp_rdata, vecs[i].erd);
         chk($sformatf("v%0d_post_strobe", i), {28'h0, p_write_n, p_read_n}, 32'hF);
         tick;
         chk($sformatf("v%0d_rsp_hold", i), {31'h0, rsp_valid}, 32'h1);
         rsp_ready = 1'b1;
         tick;
         rsp_ready = 1'b0;
         chk($sformatf("v%0d_rsp_done", i), {30'h0, rsp_valid, busy}, 32'h0);
      end
      p_ready = 1'b0;
      p_rdata = 32'hFFFF_FFFF;
      send(1'b0, 2'b10, 6'h09, 32'h0);
      for (int i = 0; i < 15; i++) begin
         tick;
         chk($sformatf("to_strobe%0d", i + 1), {29'h0, rsp_valid, p_read_n}, 32'h2);
      end
      tick;
      chk("to_strobe_off", {30'h0, p_read_n}, 32'h3);
      chk("to_rsp", {29'h0, rsp_valid, rsp_write, rsp_error}, 32'h5);
      chk("to_rdata", rsp_rdata, 32'h0);
      drain;
      p_rdata = 32'hABCD_1234;
      send(1'b0, 2'b01, 6'h07, 32'h0);
      tick;
      chk("late_strobe1", {30'h0, p_read_n}, 32'h1);
      tick;
      chk("late_strobe2", {30'h0, p_read_n}, 32'h1);
      p_ready = 1'b1;
      tick;
      chk("late_rsp", {29'h0, rsp_valid, rsp_write, rsp_error}, 32'h4);
      chk("late_rdata", rsp_rdata, 32'h0000_1234);
      chk("late_strobe_off", {30'h0, p_read_n}, 32'h3);
      drain;
      p_ready = 1'b1;
      addr_q.delete();
      mon_en = 1'b1;
      for (int i = 0; i < 5; i++) begin
         chk($sformatf("fill%0d_cmd_ready", i), {31'h0, cmd_ready}, 32'h1);
         cmd_write = 1'b1; cmd_size = 2'b10; cmd_addr = 6'(i + 1); cmd_wdata = 32'h100 + i;
         cmd_valid = 1'b1;
         tick;
      end
      chk("full_cmd_ready", {31'h0, cmd_ready}, 32'h0);
      cmd_addr = 6'h3E;
      tick;
      cmd_valid = 1'b0;
      chk("full_hold_cmd_ready", {31'h0, cmd_ready}, 32'h0);
      drain;
      mon_en = 1'b0;
      chk("fifo_rsp_count", rsp_cnt, 32'd5);
      chk("fifo_strobe_count", addr_q.size(), 32'd5);
      for (int i = 0; i < 5; i++)
         chk($sformatf("fifo_order%0d", i), {26'h0, i < addr_q.size() ? addr_q[i] : 6'h0}, i + 1);
      chk("b2b_gap", b2b_viol, 32'd0);
      p_ready = 1'b0;
      send(1'b0, 2'b10, 6'h0C, 32'h0);
      tick;
      cmd_write = 1'b1; cmd_size = 2'b10; cmd_addr = 6'h0D; cmd_valid = 1'b1;
      tick;
      cmd_valid = 1'b0;
      chk("rst_mid_read_strobe", {30'h0, p_read_n}, 32'h2);
      chk("rst_mid_busy", {31'h0, busy}, 32'h1);
      #2 rst_n = 1'b0;
      #1;
      chk("rst_async_strobes", {28'h0, p_write_n, p_read_n}, 32'hF);
      chk("rst_async_busy", {30'h0, busy, cmd_ready}, 32'h1);
      chk("rst_async_rsp", {31'h0, rsp_valid}, 32'h0);
      tick;
      rst_n = 1'b1;
      tick;
      tick;
      chk("post_rst_idle", {30'h0, busy, rsp_valid}, 32'h0);
      chk("post_rst_strobes", {28'h0, p_write_n, p_read_n}, 32'hF);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
